// File: rtl/alu_arbiter_2ch.sv
// Two-channel round-robin front end for one external 32-bit combinational ALU.
// Define ALU_ARB_STICKY_OF_EN to add the per-requester sticky overflow flags (of_sticky / of_clr).
`timescale 1ns/1ps

module alu_arbiter_2ch #(
    parameter int W   = 32,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef ALU_ARB_STICKY_OF_EN
    output logic [1:0]     of_sticky,
    input  logic           of_clr,
`endif
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_f,
    input  logic           alu_zf,
    input  logic           alu_of,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_f,
    output logic           rsp_zf,
    output logic           rsp_of
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_ADD = OPW'(4);
    localparam logic [OPW-1:0] OP_SUB = OPW'(5);

    state_t         r_state;
    state_t         w_next_state;
    logic           r_last_grant;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic [OPW-1:0] r_op_code;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [W-1:0]   r_rsp_f;
    logic           r_rsp_zf;
    logic           r_rsp_of;

    logic           w_grant_sel;
    logic           w_accept;
    logic           w_rsp_fire;
    logic           w_of_masked;

    // Round-robin pick: a lone requester always wins, a tie goes away from the last grant.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_grant_sel = ~r_last_grant;
        if (req0_valid && !req1_valid) begin
            w_grant_sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant_sel = 1'b1;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked processes use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = EXEC;
            EXEC:                    w_next_state = RESP;
            RESP:    if (w_rsp_fire) w_next_state = IDLE;
            default:                 w_next_state = IDLE;
        endcase
    end

    // FSM: outputs. Requests are only ever accepted from IDLE.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (r_state == IDLE) begin
            req0_ready = req0_valid & ~w_grant_sel;
            req1_ready = req1_valid &  w_grant_sel;
        end
        w_accept   = req0_ready | req1_ready;
        w_rsp_fire = (r_state == RESP) & r_rsp_valid & rsp_ready;
    end

    // OF is only meaningful for add/sub; the ALU leaves it undefined otherwise.
    assign w_of_masked = ((r_op_code == OP_ADD) || (r_op_code == OP_SUB)) ? alu_of : 1'b0;

    // Operand latch and arbitration history.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand registers are reset too, so the ALU never sees stale data after reset.
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_code    <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_sel;
            r_op_a       <= w_grant_sel ? req1_a  : req0_a;
            r_op_b       <= w_grant_sel ? req1_b  : req0_b;
            r_op_code    <= w_grant_sel ? req1_op : req0_op;
        end
    end

    // Response capture at the EXEC edge, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_zf    <= 1'b0;
            r_rsp_of    <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_last_grant;
            r_rsp_f     <= alu_f;
            r_rsp_zf    <= alu_zf;
            r_rsp_of    <= w_of_masked;
        end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_STICKY_OF_EN
    logic [1:0] r_of_sticky;
    logic [1:0] w_sticky_set;

    always_comb begin
        w_sticky_set = 2'b00;
        if ((r_state == EXEC) && w_of_masked) begin
            w_sticky_set[r_last_grant] = 1'b1;
        end
    end

    // A set landing on the same edge as a clear survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_of_sticky <= 2'b00;
        end else begin
            r_of_sticky <= (of_clr ? 2'b00 : r_of_sticky) | w_sticky_set;
        end
    end

    assign of_sticky = r_of_sticky;
`endif

    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_op    = r_op_code;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_f     = r_rsp_f;
    assign rsp_zf    = r_rsp_zf;
    assign rsp_of    = r_rsp_of;

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Directed bench for alu_arbiter_2ch: vector table of single ops plus stall, reset and fairness sequences.
// Exercises of_sticky/of_clr when built with ALU_ARB_STICKY_OF_EN.
`timescale 1ns/1ps

module tb_alu_arbiter_2ch;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic [31:0] alu_a, alu_b, alu_f;
    logic [2:0]  alu_op;
    logic        alu_zf, alu_of;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zf, rsp_of;
    logic [31:0] rsp_f;
`ifdef ALU_ARB_STICKY_OF_EN
    logic [1:0]  of_sticky;
    logic        of_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter_2ch #(.W(32), .OPW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ALU_ARB_STICKY_OF_EN
        .of_sticky  (of_sticky),
        .of_clr     (of_clr),
`endif
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_f      (alu_f),
        .alu_zf     (alu_zf),
        .alu_of     (alu_of),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_f      (rsp_f),
        .rsp_zf     (rsp_zf),
        .rsp_of     (rsp_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model; OF is deliberately 1 for non-arithmetic ops so the masking is visible.
    always_comb begin
        alu_f  = 32'h0;
        alu_of = 1'b1;
        case (alu_op)
            3'b000: alu_f = alu_a & alu_b;
            3'b001: alu_f = alu_a | alu_b;
            3'b010: alu_f = alu_a ^ alu_b;
            3'b011: alu_f = ~(alu_a | alu_b);
            3'b100: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'b101: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'b110: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_f = alu_b << alu_a[4:0];
        endcase
        alu_zf = (alu_f == 32'h0);
    end

    typedef struct {
        logic        ch;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] f;
        logic        zf;
        logic        of;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on a single channel; starts and ends 1ns after a rising edge.
    task automatic do_op(input logic ch, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] ef, input logic ezf, input logic eof, input logic clr_exec);
        if (ch) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        check("grant_ready", {30'd0, req1_ready, req0_ready}, ch ? 32'd2 : 32'd1);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`ifdef ALU_ARB_STICKY_OF_EN
        of_clr = clr_exec;
`endif
        #1;
        check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_op", {29'd0, alu_op}, {29'd0, op});
        tick;
`ifdef ALU_ARB_STICKY_OF_EN
        of_clr = 1'b0;
`endif
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, ch});
        check("rsp_f", rsp_f, ef);
        check("rsp_zf", {31'd0, rsp_zf}, {31'd0, ezf});
        check("rsp_of", {31'd0, rsp_of}, {31'd0, eof});
        check("resp_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick;
        check("rsp_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        exp_ch;
        logic        got;
        int          cnt0, cnt1, k;

        vecs[0] = '{1'b0, 32'h7FFF0000, 32'h7FFF0000, 3'b100, 32'hFFFE0000, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'hFFFF0000, 32'h0000FFFF, 3'b000, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h00000002, 32'h0000FFFF, 3'b111, 32'h0003FFFC, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h000000F0, 32'h00000F00, 3'b001, 32'h00000FF0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h12345678, 32'h12345678, 3'b010, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h00000000, 32'h00000000, 3'b011, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b110, 32'h00000001, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h00000005, 32'h00000003, 3'b110, 32'h00000000, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 32'h80000000, 32'h00000001, 3'b101, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 32'h00000005, 32'h00000005, 3'b101, 32'h00000000, 1'b1, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b1;
`ifdef ALU_ARB_STICKY_OF_EN
        of_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_f", rsp_f, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_op", {29'd0, alu_op}, 32'd0);
        check("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
`ifdef ALU_ARB_STICKY_OF_EN
        check("reset_sticky", {30'd0, of_sticky}, 32'd0);
`endif
        tick;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].f, vecs[i].zf, vecs[i].of, 1'b0);
        end

        // Consumer stall: response must hold and no new request may be granted.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h00000003; req0_b = 32'h00000001; req0_op = 3'b101;
        tick;
        req0_valid = 1'b0;
        tick;
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 32'h1; req1_b = 32'h1; req1_op = 3'b100;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_f", rsp_f, 32'h00000002);
            check("stall_id", {31'd0, rsp_id}, 32'd0);
            check("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick;
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        check("stall_consumed", {31'd0, rsp_valid}, 32'd0);

`ifdef ALU_ARB_STICKY_OF_EN
        of_clr = 1'b1;
        tick;
        of_clr = 1'b0;
        check("sticky_clear0", {30'd0, of_sticky}, 32'd0);
        do_op(1'b1, 32'h8FFF0000, 32'h8FFF0000, 3'b100, 32'h1FFE0000, 1'b0, 1'b1, 1'b0);
        check("sticky_ch1", {30'd0, of_sticky}, 32'd2);
        of_clr = 1'b1;
        tick;
        of_clr = 1'b0;
        check("sticky_clear1", {30'd0, of_sticky}, 32'd0);
        do_op(1'b0, 32'h7FFF0000, 32'h7FFF0000, 3'b100, 32'hFFFE0000, 1'b0, 1'b1, 1'b1);
        check("sticky_set_wins", {30'd0, of_sticky}, 32'd1);
`endif

        // Reset during EXEC after a ch0 grant: op is dropped and the tie pointer returns to ch0.
        req0_valid = 1'b1; req0_a = 32'h7FFF0000; req0_b = 32'h7FFF0000; req0_op = 3'b100;
        tick;
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_exec_alu_a", alu_a, 32'd0);
        check("rst_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Fairness: both channels request continuously, four ops each.
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd1; req0_op = 3'b101;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'b101;
        exp_ch = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            k = 0;
            while (!(req0_ready || req1_ready) && k < 10) begin
                tick;
                k++;
            end
            if (k == 10) begin
                check("fair_timeout", 32'd1, 32'd0);
                break;
            end
            got = req1_ready;
            check("fair_grant", {31'd0, got}, {31'd0, exp_ch});
            tick;
            if (got) begin
                cnt1++;
                if (cnt1 == 4) req1_valid = 1'b0;
            end else begin
                cnt0++;
                if (cnt0 == 4) req0_valid = 1'b0;
            end
            tick;
            check("fair_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("fair_rsp_id", {31'd0, rsp_id}, {31'd0, exp_ch});
            check("fair_rsp_f", rsp_f, exp_ch ? 32'hFFFFFFFF : 32'h00000001);
            tick;
            exp_ch = ~exp_ch;
        end
        check("fair_count0", cnt0, 32'd4);
        check("fair_count1", cnt1, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
